// File: rtl/calc_cmd_arbiter.sv
// Two-requester arbiter for the calculator command port. A requester keeps
// ownership from its first accepted command until its EQ_CMD completes.
module calc_cmd_arbiter #(
    parameter logic [3:0]  IDLE_CMD = 4'hD,
    parameter logic [3:0]  EQ_CMD   = 4'hE,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [3:0] req0_cmd,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_cmd,
    output logic       req1_ready,
    input  logic [1:0] calc_status,
    output logic [3:0] calc_cmd,
    output logic       owner,
    output logic       locked,
    output logic       busy,
    output logic       err,
    output logic       timeout
);

    localparam int unsigned   TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_ERROR
    } state_t;

    state_t        state, state_n;
    logic [3:0]    cmd_q, cmd_n;
    logic          owner_q, owner_n;
    logic          locked_q, locked_n;
    logic          rel_q, rel_n;
    logic          rr_q, rr_n;
    logic          to_q, to_n;
    logic [TW-1:0] cnt_q, cnt_n, cnt_inc;

    logic st_ready, st_err, st_busy;
    logic sel, grant0, grant1;

    // 11 is folded into busy: bit 0 set means the calculator is working.
    assign st_ready = (calc_status == 2'b10);
    assign st_err   = (calc_status == 2'b00);
    assign st_busy  = calc_status[0];

    always_comb begin
        if (locked_q)
            sel = owner_q;
        else if (req0_valid && req1_valid)
            sel = rr_q;
        else
            sel = !req0_valid;
    end

    assign grant0 = (state == S_IDLE) && st_ready && !sel && req0_valid;
    assign grant1 = (state == S_IDLE) && st_ready &&  sel && req1_valid;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TW'(1);

    always_comb begin
        state_n  = state;
        cmd_n    = cmd_q;
        owner_n  = owner_q;
        locked_n = locked_q;
        rel_n    = rel_q;
        rr_n     = rr_q;
        to_n     = to_q;
        cnt_n    = cnt_q;
        case (state)
            S_IDLE: begin
                if (st_err) begin
                    state_n = S_ERROR;
                    cmd_n   = IDLE_CMD;
                end else if (grant0 || grant1) begin
                    cmd_n    = grant1 ? req1_cmd : req0_cmd;
                    owner_n  = grant1;
                    locked_n = 1'b1;
                    rel_n    = ((grant1 ? req1_cmd : req0_cmd) == EQ_CMD);
                    cnt_n    = '0;
                    state_n  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_n = cnt_inc;
                if (st_err) begin
                    state_n = S_ERROR;
                    cmd_n   = IDLE_CMD;
                end else if (st_busy) begin
                    state_n = S_WAIT_DONE;
                    cnt_n   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_n = S_ERROR;
                    cmd_n   = IDLE_CMD;
                    to_n    = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                cnt_n = cnt_inc;
                if (st_ready) begin
                    state_n = S_IDLE;
                    cmd_n   = IDLE_CMD;
                    if (rel_q) begin
                        locked_n = 1'b0;
                        rr_n     = ~owner_q;
                    end
                end else if (st_err) begin
                    state_n = S_ERROR;
                    cmd_n   = IDLE_CMD;
                end else if (cnt_q == CNT_LAST) begin
                    state_n = S_ERROR;
                    cmd_n   = IDLE_CMD;
                    to_n    = 1'b1;
                end
            end
            S_ERROR: begin
                cmd_n = IDLE_CMD;
            end
            default: begin
                state_n = S_ERROR;
                cmd_n   = IDLE_CMD;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cmd_q    <= IDLE_CMD;
            owner_q  <= 1'b0;
            locked_q <= 1'b0;
            rel_q    <= 1'b0;
            rr_q     <= 1'b0;
            to_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state    <= state_n;
            cmd_q    <= cmd_n;
            owner_q  <= owner_n;
            locked_q <= locked_n;
            rel_q    <= rel_n;
            rr_q     <= rr_n;
            to_q     <= to_n;
            cnt_q    <= cnt_n;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign calc_cmd   = cmd_q;
    assign owner      = owner_q;
    assign locked     = locked_q;
    assign busy       = (state != S_IDLE);
    assign err        = (state == S_ERROR);
    assign timeout    = to_q;

endmodule

// File: tb/tb_calc_cmd_arbiter.sv
// Scoreboard bench for calc_cmd_arbiter: directed scenarios followed by
// random episodes, all checked against a transaction-level reference model.
module tb_calc_cmd_arbiter;

    localparam int T = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_cmd = 4'h0, req1_cmd = 4'h0;
    logic [1:0] calc_status = 2'b10;
    logic       req0_ready, req1_ready;
    logic [3:0] calc_cmd;
    logic       owner, locked, busy, err, timeout;

    calc_cmd_arbiter #(.IDLE_CMD(4'hD), .EQ_CMD(4'hE), .TIMEOUT(T)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
        .calc_status(calc_status), .calc_cmd(calc_cmd), .owner(owner),
        .locked(locked), .busy(busy), .err(err), .timeout(timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       r0, r1;
        logic [3:0] cmd;
        logic       own, lck, bsy, er, to;
    } snap_t;
    typedef struct {
        logic       who;
        logic [3:0] cmd;
    } acc_t;

    snap_t snap_q[$];
    acc_t  acc_q[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: who holds the calculator, what was sent, how long we waited.
    bit         m_dead, m_to, m_inflight, m_acked, m_release;
    int         m_holder, m_last, m_pref, m_cnt;
    logic [3:0] m_cmd;
    bit         e_r0, e_r1;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dead = 0; m_to = 0; m_inflight = 0; m_acked = 0; m_release = 0;
        m_holder = -1; m_last = 0; m_pref = 0; m_cnt = 0; m_cmd = 4'hD;
    endtask

    task automatic model_eval();
        int g;
        bit can;
        can = !m_dead && !m_inflight && (calc_status == 2'b10) && reset;
        if (m_holder >= 0)                 g = m_holder;
        else if (req0_valid && req1_valid) g = m_pref;
        else if (req0_valid)               g = 0;
        else if (req1_valid)               g = 1;
        else                               g = -1;
        e_r0 = can && (g == 0) && req0_valid;
        e_r1 = can && (g == 1) && req1_valid;
    endtask

    task automatic push_snap();
        snap_t s;
        s.r0 = e_r0; s.r1 = e_r1; s.cmd = m_cmd;
        s.own = (m_last == 1); s.lck = (m_holder >= 0);
        s.bsy = m_inflight || m_dead; s.er = m_dead; s.to = m_to;
        snap_q.push_back(s);
    endtask

    task automatic go_dead(input bit by_timeout);
        m_dead = 1; m_cmd = 4'hD;
        if (by_timeout) m_to = 1;
    endtask

    // Effect of one rising clock edge on the model.
    task automatic model_step();
        logic [1:0] st;
        acc_t a;
        st = calc_status;
        if (m_dead) begin
        end else if (!m_inflight) begin
            if (st == 2'b00) go_dead(0);
            else if (e_r0 || e_r1) begin
                a.who = e_r1;
                a.cmd = e_r1 ? req1_cmd : req0_cmd;
                acc_q.push_back(a);
                m_cmd = a.cmd; m_last = e_r1 ? 1 : 0; m_holder = m_last;
                m_release = (a.cmd == 4'hE);
                m_inflight = 1; m_acked = 0; m_cnt = 0;
            end
        end else if (st == 2'b00) begin
            go_dead(0);
        end else if (!m_acked) begin
            if (st != 2'b10) begin m_acked = 1; m_cnt = 0; end
            else if (m_cnt == T - 1) go_dead(1);
            else m_cnt++;
        end else begin
            if (st == 2'b10) begin
                m_inflight = 0; m_cmd = 4'hD;
                if (m_release) begin m_holder = -1; m_pref = 1 - m_last; end
            end else if (m_cnt == T - 1) go_dead(1);
            else m_cnt++;
        end
    endtask

    task automatic cyc(input bit rn, input bit v0, input logic [3:0] c0,
                       input bit v1, input logic [3:0] c1, input logic [1:0] st);
        @(posedge clock);
        #1;
        reset = rn;
        req0_valid = v0 & rn; req0_cmd = c0;
        req1_valid = v1 & rn; req1_cmd = c1;
        calc_status = st;
        if (!rn) model_reset();
        model_eval();
        push_snap();
        if (rn) model_step();
    endtask

    task automatic idle(input logic [1:0] st);
        cyc(1, 0, 4'h0, 0, 4'h0, st);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 4'h0, 0, 4'h0, 2'b10);
    endtask

    snap_t ms;
    acc_t  ma;

    always @(negedge clock) begin
        if (snap_q.size() != 0) begin
            ms = snap_q.pop_front();
            chk1("req0_ready", req0_ready, ms.r0);
            chk1("req1_ready", req1_ready, ms.r1);
            chk4("calc_cmd",   calc_cmd,   ms.cmd);
            chk1("owner",      owner,      ms.own);
            chk1("locked",     locked,     ms.lck);
            chk1("busy",       busy,       ms.bsy);
            chk1("err",        err,        ms.er);
            chk1("timeout",    timeout,    ms.to);
            if (req0_ready || req1_ready) begin
                chk1("accept_expected", acc_q.size() != 0, 1'b1);
                if (acc_q.size() != 0) begin
                    ma = acc_q.pop_front();
                    chk1("accept_who", req1_ready, ma.who);
                    chk4("accept_cmd", req1_ready ? req1_cmd : req0_cmd, ma.cmd);
                end
            end
        end
    end

    initial begin
        int         r, mode;
        bit         v0, v1;
        logic [3:0] c0, c1;
        logic [1:0] st;
        model_reset();

        // Basic accept, busy, complete.
        do_reset(2);
        cyc(1, 1, 4'h3, 0, 4'h0, 2'b10);
        repeat (5) idle(2'b01);
        idle(2'b10);
        idle(2'b10);

        // Tie while unlocked, then round-robin after release.
        do_reset(2);
        cyc(1, 1, 4'hE, 1, 4'h2, 2'b10);
        idle(2'b01); idle(2'b01); idle(2'b10);
        cyc(1, 1, 4'hE, 1, 4'h2, 2'b10);
        idle(2'b11); idle(2'b10);

        // Lock holds the other requester off until EQ completes.
        do_reset(2);
        cyc(1, 1, 4'h5, 0, 4'h0, 2'b10);
        idle(2'b01); idle(2'b10);
        repeat (20) cyc(1, 0, 4'h0, 1, 4'h7, 2'b10);
        cyc(1, 1, 4'hE, 1, 4'h7, 2'b10);
        cyc(1, 0, 4'h0, 1, 4'h7, 2'b01);
        cyc(1, 0, 4'h0, 1, 4'h7, 2'b10);
        cyc(1, 0, 4'h0, 1, 4'h7, 2'b10);
        idle(2'b01); idle(2'b10);

        // Calculator error in WAIT_DONE is terminal.
        do_reset(2);
        cyc(1, 1, 4'h1, 0, 4'h0, 2'b10);
        idle(2'b01); idle(2'b00);
        repeat (50) cyc(1, 1, 4'h4, 1, 4'h6, 2'b10);

        // Timeout with status stuck at ready after accept.
        do_reset(2);
        cyc(1, 1, 4'h3, 0, 4'h0, 2'b10);
        repeat (10) cyc(1, 1, 4'h3, 1, 4'h3, 2'b10);

        // Timeout in WAIT_DONE.
        do_reset(2);
        cyc(1, 0, 4'h0, 1, 4'h9, 2'b10);
        repeat (10) idle(2'b01);

        // Asynchronous reset in WAIT_DONE, away from any clock edge.
        do_reset(2);
        cyc(1, 1, 4'hE, 1, 4'h2, 2'b10);
        cyc(1, 0, 4'h0, 0, 4'h0, 2'b01);
        cyc(1, 0, 4'h0, 0, 4'h0, 2'b01);
        @(posedge clock);
        #3;
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        model_reset();
        #1;
        chk4("async_calc_cmd", calc_cmd, 4'hD);
        chk1("async_locked",   locked,   1'b0);
        chk1("async_busy",     busy,     1'b0);
        model_eval();
        push_snap();
        do_reset(1);
        cyc(1, 1, 4'h8, 1, 4'hA, 2'b10);
        idle(2'b01); idle(2'b10);

        // Random episodes; mode biases the status towards ready or busy.
        for (int ep = 0; ep < 30; ep++) begin
            mode = ep % 3;
            do_reset(2);
            for (int n = 0; n < 150; n++) begin
                r = $urandom_range(0, 199);
                if (r < 1) st = 2'b00;
                else if (mode == 0) st = (r < 80) ? 2'b01 : (r < 90) ? 2'b11 : 2'b10;
                else if (mode == 1) st = (r < 12) ? 2'b01 : 2'b10;
                else                st = (r < 170) ? 2'b01 : (r < 180) ? 2'b11 : 2'b10;
                v0 = ($urandom_range(0, 9) < 6);
                v1 = ($urandom_range(0, 9) < 6);
                c0 = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
                c1 = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
                if ($urandom_range(0, 199) == 0)
                    cyc(0, 0, 4'h0, 0, 4'h0, st);
                else
                    cyc(1, v0, c0, v1, c1, st);
            end
        end

        idle(2'b10);
        @(negedge clock);
        #1;
        chk1("accept_queue_drained", acc_q.size() == 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
